muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle sequencer for RV32M MUL/DIV. Sits in EX beside the ALU: accepts the decoder's
//  4-bit mulDiv_op plus operands, stalls the pipeline while an iterative shift-add multiplier /
//  restoring divider runs, and presents one XLEN result with a 1-cycle done strobe.
//  Handles RISC-V special cases (divide-by-zero, signed overflow) on a short path. Supports flush.
// PARAMETERS
//  XLEN      32  operand/result width
//  FAST_SPEC 1   1: div-by-zero/overflow finish in 1 cycle; 0: run full iteration count
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  mulDiv_op    in   4     decoder op; 0 = none. MUL=0011 MULH=0101 MULHSU=0110 MULHU=0111
//                          DIV=1001 DIVU=1011 REM=1101 REMU=1111; other nonzero codes = no-op
//  start        in   1     EX stage holds a valid instruction (qualifies mulDiv_op)
//  flush        in   1     kill in-flight op (trap/branch redirect)
//  rs1_val      in   XLEN  operand a (multiplicand / dividend)
//  rs2_val      in   XLEN  operand b (multiplier / divisor)
//  stall        out  1     freeze IF/ID/EX; combinational
//  done         out  1     result valid, one cycle
//  result       out  XLEN  registered result; holds last value until next done
//  busy         out  1     FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, count=0, done=0, result=0, busy=0, stall=0. Reset overrides all, incl. mid-op.
//  req = start & (mulDiv_op is a legal code) & ~flush.
//  stall = (IDLE & req) | BUSY. Deasserted in DONE so the instruction retires that cycle.
//  FSM:
//   IDLE -> BUSY  on req: latch op, |a|,|b| (signed per op; MULHSU: a signed, b unsigned),
//                 result sign, count=0.
//   IDLE -> DONE  on req & FAST_SPEC & special case: result loaded directly.
//   BUSY -> BUSY  count<XLEN-1: one iteration/cycle, count++.
//   BUSY -> DONE  count==XLEN-1: final iteration; sign fixup; result register written.
//   DONE -> IDLE  unconditionally; done=1 only in DONE.
//   any  -> IDLE  on flush (priority over all but rst); done not asserted; result unchanged.
//  Latency: request in cycle 0; iterative ops done in cycle XLEN+1 (33); special cases in cycle 1.
//  A request seen in DONE is ignored (same instruction retiring); next op accepted from IDLE only.
//  Arithmetic:
//   MUL: low XLEN of 2*XLEN product; MULH/MULHSU/MULHU: high XLEN, signedness per op.
//   Product magnitude 2*XLEN; negate full 2*XLEN before selecting half.
//   DIV/REM: quotient sign = sa^sb; remainder sign = dividend sign. Truncates toward zero.
//   Div-by-zero: DIV/DIVU -> all ones; REM/REMU -> dividend.
//   Overflow (DIV/REM, a=-2^(XLEN-1), b=-1): DIV -> a, REM -> 0.
//   Operands sampled only on IDLE->BUSY; later changes to rs1_val/rs2_val are ignored.
//  Illegal nonzero op codes: no request, stall=0, no done.
// STRUCTURE
//  muldiv_pkg: op-code localparams (OP_MUL..OP_REMU), state encoding, XLEN default.
//  Sub-module muldiv_iter: one-step datapath (shift-add or restore-subtract) on
//  {acc, q/multiplier} registers; FSM, counter, sign logic, special-case detect in muldiv_ctrl.
// TESTING
//  MUL 7 * -3 (0xFFFFFFFD) -> stall cycles 0..32, done at cycle 33, result=0xFFFFFFEB.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
//  DIVU 100/0 -> done cycle 1, 0xFFFFFFFF; REM 0x80000000 % -1 -> done cycle 1, result 0.
//  DIV issued, flush at cycle 10 -> IDLE cycle 11, no done, result unchanged;
//  new MUL cycle 12 -> done cycle 45.
//  rst at cycle 5 of MUL -> cycle 6: busy=0, stall=0, done=0, result=0.
//  Op 0100 with start=1 -> stall=0, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Contents: default XLEN, decoder op-code constants, FSM state type, op-code helpers.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] OP_NONE   = 4'b0000;
   localparam logic [3:0] OP_MUL    = 4'b0011;
   localparam logic [3:0] OP_MULH   = 4'b0101;
   localparam logic [3:0] OP_MULHSU = 4'b0110;
   localparam logic [3:0] OP_MULHU  = 4'b0111;
   localparam logic [3:0] OP_DIV    = 4'b1001;
   localparam logic [3:0] OP_DIVU   = 4'b1011;
   localparam logic [3:0] OP_REM    = 4'b1101;
   localparam logic [3:0] OP_REMU   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   // All legal divide/remainder codes have bit 3 set, all multiply codes clear it.
   function automatic logic op_is_div(input logic [3:0] op);
      return op[3];
   endfunction

   // REM/REMU are the divide codes with bit 2 set.
   function automatic logic op_is_rem(input logic [3:0] op);
      return op[3] & op[2];
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage handshake between the pipeline and the MUL/DIV sequencer.
// master (pipeline): drives mulDiv_op, start, flush, rs1_val, rs2_val;
//                    observes stall, done, result, busy.
// slave (sequencer): the reverse.
interface muldiv_ctrl_if #(
   parameter int XLEN = muldiv_pkg::XLEN_DEFAULT
);
   logic [3:0]      mulDiv_op;
   logic            start;
   logic            flush;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output mulDiv_op, start, flush, rs1_val, rs2_val,
      input  stall, done, result, busy
   );

   modport slave (
      input  mulDiv_op, start, flush, rs1_val, rs2_val,
      output stall, done, result, busy
   );
endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned magnitude datapath, purely combinational.
// Multiply: shift-add on {acc, lo}, lo holds the multiplier, opnd the multiplicand.
// Divide:   restoring step on {acc, lo}, lo holds dividend/quotient, opnd the divisor.
// Ports: is_div selects the step; acc/lo current state; acc_next/lo_next next state.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opnd,
   output logic [XLEN-1:0] acc_next,
   output logic [XLEN-1:0] lo_next
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   always_comb begin
      sum      = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
      shifted  = {acc, lo[XLEN-1]};
      trial    = shifted - {1'b0, opnd};
      acc_next = '0;
      lo_next  = '0;
      if (is_div) begin
         // Remainder stays below the divisor, so a set top bit means the trial went negative.
         if (!trial[XLEN]) begin
            acc_next = trial[XLEN-1:0];
            lo_next  = {lo[XLEN-2:0], 1'b1};
         end else begin
            acc_next = shifted[XLEN-1:0];
            lo_next  = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_next = sum[XLEN:1];
         lo_next  = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle RV32M MUL/DIV sequencer sitting beside the ALU in EX.
// Latches op and operand magnitudes on acceptance, iterates XLEN cycles through
// muldiv_iter, applies the sign fixup and pulses done for one cycle.
// Divide-by-zero and signed overflow can complete in one cycle (FAST_SPEC).
// Ports: clk, rst (sync, active high); bus = slave side of muldiv_ctrl_if.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter bit FAST_SPEC = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_ctrl_if.slave bus
);

   localparam int              CW      = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state;
   logic [CW-1:0]     count;
   logic [3:0]        op_r;
   logic [XLEN-1:0]   acc, lo, opnd;
   logic              neg_r, spec_r;
   logic [XLEN-1:0]   spec_val_r;
   logic              done_r;
   logic [XLEN-1:0]   result_r;

   logic              req, is_div, a_signed, b_signed, sa, sb, neg_in, special;
   logic [XLEN-1:0]   a, b, mag_a, mag_b, spec_val;
   logic [XLEN-1:0]   acc_n, lo_n, div_val, div_s, fin;
   logic [2*XLEN-1:0] prod, prod_s;

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .is_div   (op_is_div(op_r)),
      .acc      (acc),
      .lo       (lo),
      .opnd     (opnd),
      .acc_next (acc_n),
      .lo_next  (lo_n)
   );

   always_comb begin
      a        = bus.rs1_val;
      b        = bus.rs2_val;
      req      = bus.start & op_legal(bus.mulDiv_op) & ~bus.flush;
      is_div   = op_is_div(bus.mulDiv_op);
      a_signed = (bus.mulDiv_op == OP_MULH) || (bus.mulDiv_op == OP_MULHSU) ||
                 (bus.mulDiv_op == OP_DIV)  || (bus.mulDiv_op == OP_REM);
      b_signed = (bus.mulDiv_op == OP_MULH) || (bus.mulDiv_op == OP_DIV) ||
                 (bus.mulDiv_op == OP_REM);
      sa       = a_signed & a[XLEN-1];
      sb       = b_signed & b[XLEN-1];
      mag_a    = sa ? -a : a;
      mag_b    = sb ? -b : b;
      neg_in   = op_is_rem(bus.mulDiv_op) ? sa : (sa ^ sb);
      special  = 1'b0;
      spec_val = '0;
      if (is_div && (b == '0)) begin
         special  = 1'b1;
         spec_val = op_is_rem(bus.mulDiv_op) ? a : '1;
      end else if (a_signed && is_div && (a == MIN_NEG) && (b == '1)) begin
         special  = 1'b1;
         spec_val = op_is_rem(bus.mulDiv_op) ? '0 : a;
      end

      // Final-step result taken from the iterator's outputs so it lands with the last step.
      prod    = {acc_n, lo_n};
      prod_s  = neg_r ? -prod : prod;
      div_val = op_is_rem(op_r) ? acc_n : lo_n;
      div_s   = neg_r ? -div_val : div_val;
      if (spec_r)
         fin = spec_val_r;
      else if (op_is_div(op_r))
         fin = div_s;
      else if (op_r == OP_MUL)
         fin = prod_s[XLEN-1:0];
      else
         fin = prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         op_r       <= OP_NONE;
         acc        <= '0;
         lo         <= '0;
         opnd       <= '0;
         neg_r      <= 1'b0;
         spec_r     <= 1'b0;
         spec_val_r <= '0;
         done_r     <= 1'b0;
         result_r   <= '0;
      end else begin
         done_r <= 1'b0;
         if (bus.flush) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (req) begin
                  op_r       <= bus.mulDiv_op;
                  acc        <= '0;
                  lo         <= is_div ? mag_a : mag_b;
                  opnd       <= is_div ? mag_b : mag_a;
                  neg_r      <= neg_in;
                  spec_r     <= special;
                  spec_val_r <= spec_val;
                  count      <= '0;
                  if (FAST_SPEC && special) begin
                     result_r <= spec_val;
                     done_r   <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     state <= ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  acc   <= acc_n;
                  lo    <= lo_n;
                  count <= count + 1'b1;
                  if (count == LAST) begin
                     result_r <= fin;
                     done_r   <= 1'b1;
                     state    <= ST_DONE;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.stall  = ((state == ST_IDLE) & req) | (state == ST_BUSY);
   assign bus.busy   = (state != ST_IDLE);
   assign bus.done   = done_r;
   assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed RV32M vectors, randomized ops with
// an arithmetic reference model, flush, mid-op reset, illegal codes, back-to-back issue.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

   muldiv_ctrl #(.XLEN(XLEN), .FAST_SPEC(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [3:0] legal_ops [8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                 OP_DIV, OP_DIVU, OP_REM, OP_REMU};

   // Reference: plain 64-bit and 32-bit arithmetic, RISC-V special-case rules.
   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint ax, bx, p;
      int ia, ib;
      logic ovf;
      ia  = a;
      ib  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      ax  = longint'({32'b0, a});
      bx  = longint'({32'b0, b});
      if (op == OP_MULH || op == OP_MULHSU) ax = longint'(ia);
      if (op == OP_MULH) bx = longint'(ib);
      p = ax * bx;
      case (op)
         OP_MUL:    return p[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
         OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
         OP_REMU:   return (b == 0) ? a : a % b;
         default:   return 32'h0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op[3] && b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issue one op as cycle 0 and follow it to done; operands are scrambled while busy.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit keep_start, output logic [31:0] got);
      logic [31:0] exp;
      int exp_lat;
      bit seen;
      exp     = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      got     = 'x;
      @(negedge clk);
      bus.mulDiv_op = op; bus.start = 1'b1; bus.flush = 1'b0;
      bus.rs1_val = a; bus.rs2_val = b;
      #1;
      n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL issue_stall op=%b: got %b want 1", op, bus.stall); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL issue_busy op=%b: got %b want 0", op, bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL issue_done op=%b: got %b want 0", op, bus.done); end
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk); #1;
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            got  = bus.result;
            n_cmp++; if (k !== exp_lat) begin n_fail++; $display("FAIL latency op=%b a=%h b=%h: got %0d want %0d", op, a, b, k, exp_lat); end
            n_cmp++; if (bus.result !== exp) begin n_fail++; $display("FAIL result op=%b a=%h b=%h: got %h want %h", op, a, b, bus.result, exp); end
            n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL done_stall op=%b: got %b want 0", op, bus.stall); end
            n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL done_busy op=%b: got %b want 1", op, bus.busy); end
            if (!keep_start) bus.start = 1'b0;
         end else begin
            n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL busy_stall op=%b cyc=%0d: got %b want 1", op, k, bus.stall); end
            n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag op=%b cyc=%0d: got %b want 1", op, k, bus.busy); end
            bus.rs1_val = $urandom;
            bus.rs2_val = $urandom;
         end
      end
      if (!seen) begin
         n_cmp++; n_fail++;
         $display("FAIL timeout op=%b a=%h b=%h: got no done want done at %0d", op, a, b, exp_lat);
         bus.start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mulDiv_op = OP_NONE; bus.start = 1'b0; bus.flush = 1'b0;
      bus.rs1_val = '0; bus.rs2_val = '0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [3:0]  ops  [10] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_DIV,
                                 OP_REM, OP_DIVU, OP_REMU, OP_DIVU, OP_REM};
      logic [31:0] as   [10] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                 32'hFFFFFFF9, 32'd100, 32'd100, 32'd100, 32'h80000000};
      logic [31:0] bs   [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                 32'd2, 32'd7, 32'd7, 32'd0, 32'hFFFFFFFF};
      logic [31:0] want [10] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h0};
      logic [31:0] got;
      for (int i = 0; i < 10; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b0, got);
         n_cmp++; if (got !== want[i]) begin n_fail++; $display("FAIL directed_%0d: got %h want %h", i, got, want[i]); end
      end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b, got;
      for (int i = 0; i < 40; i++) begin
         op = legal_ops[$urandom_range(0, 7)];
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
            3: b = -($urandom_range(1, 9));
            default: ;
         endcase
         run_op(op, a, b, 1'b0, got);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_flush();
      logic [31:0] prev, got;
      @(negedge clk);
      prev = bus.result;
      bus.mulDiv_op = OP_DIV; bus.start = 1'b1; bus.flush = 1'b0;
      bus.rs1_val = 32'hFFFFFFF9; bus.rs2_val = 32'd2;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_nodone cyc=%0d: got %b want 0", k, bus.done); end
         if (k == 10) bus.flush = 1'b1;
      end
      @(negedge clk);
      bus.flush = 1'b0; bus.start = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== prev) begin n_fail++; $display("FAIL flush_result: got %h want %h", bus.result, prev); end
      run_op(OP_MUL, 32'd123456, 32'd789, 1'b0, got);
      // Flush in the same cycle as the request: nothing is accepted.
      @(negedge clk);
      bus.mulDiv_op = OP_DIVU; bus.start = 1'b1; bus.flush = 1'b1;
      #1;
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_issue_stall: got %b want 0", bus.stall); end
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_issue_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] got;
      run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 1'b0, got);
      @(negedge clk);
      bus.mulDiv_op = OP_MUL; bus.start = 1'b1; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      rst = 1'b1; bus.start = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", bus.stall); end
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
      rst = 1'b0;
   endtask

   task automatic test_illegal();
      logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                4'b1000, 4'b1010, 4'b1100, 4'b1110};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.mulDiv_op = codes[i]; bus.start = 1'b1; bus.rs1_val = $urandom; bus.rs2_val = $urandom;
         #1;
         n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL illegal_stall op=%b: got %b want 0", codes[i], bus.stall); end
         for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
               n_fail++; $display("FAIL illegal_idle op=%b: got done=%b busy=%b want 0 0", codes[i], bus.done, bus.busy);
            end
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      // start stays high through each done cycle; that request is the retiring one.
      run_op(OP_MULHU, $urandom, $urandom, 1'b1, got);
      run_op(OP_REMU, $urandom, 32'd0, 1'b1, got);
      run_op(OP_DIV, $urandom, $urandom_range(1, 1000), 1'b1, got);
      run_op(OP_MULHSU, $urandom, $urandom, 1'b0, got);
      @(negedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_reset_mid_op();
      test_illegal();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
